// File: rtl/noc_outport_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_outport_rr_arbiter_if
//   Bundles the signals between the input FIFOs / downstream link and one
//   output-port arbiter.
//   master : FIFO / link side -- drives req, in_data, dcts; sees the results
//   slave  : arbiter side     -- consumes requests, drives pops and TX stage
//   Signals:
//     req      NUM_IN             FIFO i non-empty and head flit routed here
//     in_data  NUM_IN*DATA_WIDTH  head flit of FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//     dcts     1                  downstream clear-to-send
//     rd_en    NUM_IN             one-hot pop strobe to the owner FIFO
//     tx_data  DATA_WIDTH         registered outgoing flit
//     rts      1                  registered request-to-send, one cycle per flit
//     busy     1                  port locked to a packet
//     owner    PTR_W              index of current or last owner
//     len_err  1                  flit count and TAIL id disagreed
// ---------------------------------------------------------------------------
interface noc_outport_rr_arbiter_if #(
    parameter int NUM_IN     = 5,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_W      = 3
);
    logic [NUM_IN-1:0]            req;
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic                         dcts;
    logic [NUM_IN-1:0]            rd_en;
    logic [DATA_WIDTH-1:0]        tx_data;
    logic                         rts;
    logic                         busy;
    logic [PTR_W-1:0]             owner;
    logic                         len_err;

    modport master (
        output req, in_data, dcts,
        input  rd_en, tx_data, rts, busy, owner, len_err
    );

    modport slave (
        input  req, in_data, dcts,
        output rd_en, tx_data, rts, busy, owner, len_err
    );
endinterface

// File: rtl/noc_outport_rr_arbiter.sv
// ---------------------------------------------------------------------------
// noc_outport_rr_arbiter
//   Per-output-port unit of the router: round-robin wormhole arbiter, FIFO
//   pop generator and registered TX stage. A header at the head of a
//   requesting FIFO wins the port, which then stays locked to that input
//   until the packet ends (flit count reaches 1 or a TAIL is popped).
//   Ports:
//     clk   clock
//     rst   asynchronous reset, active high
//     link  noc_outport_rr_arbiter_if.slave (req/in_data/dcts in,
//           rd_en/tx_data/rts/busy/owner/len_err out)
// ---------------------------------------------------------------------------
module noc_outport_rr_arbiter #(
    parameter int NUM_IN     = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int PTR_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    noc_outport_rr_arbiter_if.slave     link
);

    localparam logic [2:0] ID_HEADER = 3'b001;
    localparam logic [2:0] ID_TAIL   = 3'b100;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                 state, state_next;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       owner_q;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]  tx_q;
    logic                   rts_q;
    logic                   len_err_q;

    logic [PTR_W-1:0]       winner;
    logic                   grant_found;
    logic [DATA_WIDTH-1:0]  sel_flit;
    logic                   owner_req;
    logic                   pop;
    logic                   cnt_one;
    logic                   is_tail;
    logic                   is_last;
    logic [NUM_IN-1:0]      rd_en;

    function automatic logic [2:0] flit_id(input logic [DATA_WIDTH-1:0] f);
        return f[DATA_WIDTH-1 -: 3];
    endfunction

    function automatic logic [LEN_WIDTH-1:0] flit_len(input logic [DATA_WIDTH-1:0] f);
        return f[DATA_WIDTH-4 -: LEN_WIDTH];
    endfunction

    // Round-robin search: the port just after the last owner has top
    // priority; only requesters presenting a header are eligible.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        winner      = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            automatic int idx = (int'(rr_ptr) + k) % NUM_IN;
            if (!grant_found && link.req[idx] &&
                flit_id(link.in_data[idx*DATA_WIDTH +: DATA_WIDTH]) == ID_HEADER) begin
                grant_found = 1'b1;
                winner      = PTR_W'(idx);
            end
        end
    end

    // Owner's head flit and request, muxed without a variable-width index.
    always_comb begin
        sel_flit  = '0;
        owner_req = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (owner_q == PTR_W'(i)) begin
                sel_flit  = link.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                owner_req = link.req[i];
            end
        end
    end

    // FSM: state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM: next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_found) state_next = XFER;
            XFER: if (is_last)     state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // FSM: outputs. rd_en is combinational so a pop costs no extra cycle;
    // it falls with state on an asynchronous reset.
    always_comb begin
        pop     = (state == XFER) && owner_req && link.dcts;
        cnt_one = (cnt == LEN_WIDTH'(1));
        is_tail = (flit_id(sel_flit) == ID_TAIL);
        // Either condition ends the packet; a disagreement is reported.
        is_last = pop && (cnt_one || is_tail);
        for (int i = 0; i < NUM_IN; i++) begin
            rd_en[i] = pop && (owner_q == PTR_W'(i));
        end
    end

    // Grant bookkeeping and registered TX stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= PTR_W'(NUM_IN - 1);
            owner_q   <= '0;
            cnt       <= '0;
            tx_q      <= '0;
            rts_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            rts_q     <= 1'b0;
            len_err_q <= 1'b0;
            if (state == IDLE) begin
                if (grant_found) begin
                    owner_q <= winner;
                    // A zero length is treated as a single-flit packet.
                    cnt <= (flit_len(link.in_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH]) == '0)
                         ? LEN_WIDTH'(1)
                         : flit_len(link.in_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH]);
                end
            end else if (pop) begin
                tx_q      <= sel_flit;
                rts_q     <= 1'b1;
                cnt       <= cnt - LEN_WIDTH'(1);
                len_err_q <= cnt_one ^ is_tail;
                if (is_last) rr_ptr <= owner_q;
            end
        end
    end

    assign link.rd_en   = rd_en;
    assign link.tx_data = tx_q;
    assign link.rts     = rts_q;
    assign link.busy    = (state == XFER);
    assign link.owner   = owner_q;
    assign link.len_err = len_err_q;

endmodule

// File: tb/tb_noc_outport_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_outport_rr_arbiter
//   Drives per-port FIFO queues into the arbiter and compares every cycle
//   against a packet-level reference: which port holds the output, how many
//   flits it still owes, and who was served last.
// ---------------------------------------------------------------------------
module tb_noc_outport_rr_arbiter;

    localparam int NUM_IN     = 5;
    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 12;
    localparam int PTR_W      = 3;

    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_outport_rr_arbiter_if #(
        .NUM_IN(NUM_IN), .DATA_WIDTH(DATA_WIDTH), .PTR_W(PTR_W)
    ) link ();

    noc_outport_rr_arbiter #(
        .NUM_IN(NUM_IN), .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH(LEN_WIDTH), .PTR_W(PTR_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus state
    logic [DATA_WIDTH-1:0] fifo [NUM_IN][$];
    logic                  dcts_pat [$];
    bit                    rand_dcts;
    bit                    rand_req;

    // Reference state: packet-level view of the port
    bit                    m_locked;
    int                    m_owner;
    int                    m_left;
    int                    m_last;
    logic [DATA_WIDTH-1:0] m_tx;
    bit                    m_rts;
    bit                    m_len_err;

    function automatic logic [2:0] id_of(input logic [DATA_WIDTH-1:0] f);
        return f[31:29];
    endfunction

    function automatic int len_of(input logic [DATA_WIDTH-1:0] f);
        return int'(f[28:17]);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mk(input logic [2:0] id, input int len);
        logic [DATA_WIDTH-1:0] f;
        f        = DATA_WIDTH'($urandom);
        f[31:29] = id;
        if (id == HDR) f[28:17] = LEN_WIDTH'(len);
        return f;
    endfunction

    // kind 0: well formed; 1: TAIL arrives before the count (n flits < len);
    // 2: no TAIL, ends on count.
    task automatic push_packet(input int port, input int len, input int kind, input int n);
        fifo[port].push_back(mk(HDR, len));
        if (kind == 0) begin
            for (int j = 1; j < len; j++) fifo[port].push_back(mk((j == len-1) ? TAIL : BODY, 0));
        end else if (kind == 1) begin
            for (int j = 1; j < n; j++) fifo[port].push_back(mk((j == n-1) ? TAIL : BODY, 0));
        end else begin
            for (int j = 1; j < len; j++) fifo[port].push_back(mk(BODY, 0));
        end
    endtask

    task automatic model_reset();
        m_locked  = 0;
        m_owner   = 0;
        m_left    = 0;
        m_last    = NUM_IN - 1;
        m_tx      = '0;
        m_rts     = 0;
        m_len_err = 0;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NUM_IN; i++) fifo[i].delete();
        dcts_pat.delete();
    endtask

    // One clock: check registered outputs, drive inputs, check the pop
    // strobe, then advance the reference by one edge.
    task automatic step();
        logic [NUM_IN-1:0]     exp_rd;
        logic [DATA_WIDTH-1:0] flit;
        bit                    found;
        bit                    by_count;
        bit                    by_tail;
        @(negedge clk);
        check("rts",     link.rts,     m_rts);
        check("tx_data", link.tx_data, m_tx);
        check("len_err", link.len_err, m_len_err);
        check("busy",    link.busy,    m_locked);
        check("owner",   link.owner,   m_owner);

        for (int i = 0; i < NUM_IN; i++) begin
            link.in_data[i*DATA_WIDTH +: DATA_WIDTH] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
            link.req[i] = (fifo[i].size() > 0) && (!rand_req || $urandom_range(0, 3) != 0);
        end
        if (dcts_pat.size() > 0) link.dcts = dcts_pat.pop_front();
        else                     link.dcts = rand_dcts ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;

        exp_rd = '0;
        if (!m_locked) begin
            m_rts     = 0;
            m_len_err = 0;
            found     = 0;
            for (int k = 1; k <= NUM_IN; k++) begin
                automatic int i = (m_last + k) % NUM_IN;
                flit = link.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                if (!found && link.req[i] && id_of(flit) == HDR) begin
                    found    = 1;
                    m_locked = 1;
                    m_owner  = i;
                    m_left   = (len_of(flit) == 0) ? 1 : len_of(flit);
                end
            end
        end else if (link.req[m_owner] && link.dcts) begin
            flit            = link.in_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
            exp_rd[m_owner] = 1'b1;
            m_tx            = flit;
            m_rts           = 1;
            by_count        = (m_left == 1);
            by_tail         = (id_of(flit) == TAIL);
            m_len_err       = by_count != by_tail;
            m_left          = m_left - 1;
            if (by_count || by_tail) begin
                m_locked = 0;
                m_last   = m_owner;
            end
            void'(fifo[m_owner].pop_front());
        end else begin
            m_rts     = 0;
            m_len_err = 0;
        end
        check("rd_en", link.rd_en, exp_rd);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        rst          = 1'b1;
        link.req     = '0;
        link.in_data = '0;
        link.dcts    = 1'b0;
        rand_dcts    = 0;
        rand_req     = 0;
        model_reset();
        clear_fifos();

        // Reset state
        #12;
        check("rst_rts",     link.rts,     1'b0);
        check("rst_busy",    link.busy,    1'b0);
        check("rst_owner",   link.owner,   '0);
        check("rst_tx",      link.tx_data, '0);
        check("rst_len_err", link.len_err, 1'b0);
        check("rst_rd_en",   link.rd_en,   '0);
        @(negedge clk);
        rst = 1'b0;

        // T1: reset mid-packet drops outputs with no clock edge
        push_packet(2, 6, 0, 0);
        run(3);
        check("t1_pre_rd_en", link.rd_en, 5'b00100);
        #1 rst = 1'b1;
        #1;
        check("t1_rts",     link.rts,     1'b0);
        check("t1_rd_en",   link.rd_en,   '0);
        check("t1_busy",    link.busy,    1'b0);
        check("t1_len_err", link.len_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_fifos();
        push_packet(4, 2, 0, 0);
        push_packet(0, 2, 0, 0);
        run(10);

        // T2: single 4-flit packet from port 2
        push_packet(2, 4, 0, 0);
        run(8);

        // T3: round robin across ports 0,1,3
        for (int r = 0; r < 2; r++) begin
            push_packet(0, 2, 0, 0);
            push_packet(1, 2, 0, 0);
            push_packet(3, 2, 0, 0);
        end
        run(22);

        // T4: dcts gap after header; port 1 waits
        push_packet(0, 3, 0, 0);
        push_packet(1, 1, 0, 0);
        dcts_pat.push_back(1'b1);
        dcts_pat.push_back(1'b1);
        dcts_pat.push_back(1'b0);
        dcts_pat.push_back(1'b0);
        dcts_pat.push_back(1'b0);
        run(12);

        // T5: early TAIL and missing TAIL
        push_packet(3, 5, 1, 3);
        run(8);
        push_packet(1, 2, 2, 0);
        run(6);

        // T6: zero length header; BODY stuck at a FIFO head
        push_packet(4, 0, 0, 0);
        fifo[2].push_back(mk(BODY, 0));
        run(10);
        clear_fifos();
        run(2);

        // Randomised traffic with request gaps and backpressure
        rand_dcts = 1;
        rand_req  = 1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                automatic int port = $urandom_range(0, NUM_IN-1);
                automatic int kind = $urandom_range(0, 2);
                automatic int len  = $urandom_range(0, 6);
                if (fifo[port].size() < 12) begin
                    if (kind == 1 && len >= 3) push_packet(port, len, 1, $urandom_range(2, len-1));
                    else                       push_packet(port, len, (kind == 2) ? 2 : 0, 0);
                end
            end
            step();
        end
        rand_dcts = 0;
        rand_req  = 0;
        run(300);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
